mem_ctrl: RTL



---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/mem_lane_align.sv | 31 +++
 rtl/mem_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the RV32I memory controller.
// FSM state codes, store_size encodings, the NOP instruction word and the
// alignment rule used by both the lane aligner and the controller.
package mem_ctrl_pkg;

  // FSM state encoding (kept as plain constants for legacy tools)
  typedef logic [1:0] state_t;
  localparam state_t FETCH = 2'd0;
  localparam state_t EXEC  = 2'd1;
  localparam state_t DATA  = 2'd2;
  localparam state_t DONE  = 2'd3;

  // store_size encodings driven by the core
  localparam logic [1:0] SZ_B    = 2'b00;
  localparam logic [1:0] SZ_H    = 2'b01;
  localparam logic [1:0] SZ_W    = 2'b10;
  localparam logic [1:0] SZ_LOAD = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Loads carry no width, so only half/word stores can be misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering.
// Builds byte enables and lane-shifted write data for stores, right-justifies
// read data by the byte offset, and flags misaligned half/word stores.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_shifted,
  output logic [31:0] rdata_aligned,
  output logic        misal
);

  // Lane selection from access size and byte offset
  always_comb begin
    be            = 4'b1111;
    wdata_shifted = 32'h0;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    if (size != SZ_LOAD) wdata_shifted = wdata << {off, 3'b000};
    rdata_aligned = rdata >> {off, 3'b000};
    misal         = misaligned(size, off);
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises instruction fetch and data load/store from a
// single-cycle RV32I core onto one single-port word-addressed bus.
// Optional feature: define MEM_CTRL_TIMEOUT_EN to abort bus waits after
// TIMEOUT_CYCLES request cycles and raise the sticky bus_err flag.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        memory_en,
  input  logic [1:0]  store_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] instr_fetch,
  output logic [31:0] mem_read_data,
  output logic        stall_mem,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  state_t      state;
  logic [31:2] fetch_pc;
  logic [31:0] instr_reg;
  logic [31:0] rdata_reg;
  logic        d_we;
  logic [31:2] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misal;
  logic        req_active;
  logic        tmo;
  logic        unused_bits;

  mem_lane_align u_align (
    .size          (store_size),
    .off           (mem_addr[1:0]),
    .wdata         (mem_write_data),
    .rdata         (bus_rdata),
    .be            (al_be),
    .wdata_shifted (al_wdata),
    .rdata_aligned (al_rdata),
    .misal         (al_misal)
  );

  assign req_active    = (state == FETCH) || (state == DATA);
  assign instr_fetch   = instr_reg;
  assign mem_read_data = rdata_reg;

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  assign tmo     = req_active && !bus_ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign bus_err = err_q;

  // Wait counter restarts with every request phase; error flag is sticky
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (!req_active || bus_ack || tmo) tmo_cnt <= '0;
      else                               tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo) err_q <= 1'b1;
    end
  end

  assign unused_bits = ^next_pc[1:0];
`else
  assign tmo         = 1'b0;
  assign bus_err     = 1'b0;
  assign unused_bits = ^{next_pc[1:0], (TIMEOUT_CYCLES > 0)};
`endif

  // Control FSM plus the fetch PC and the instruction/load holding registers
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC[31:2];
      instr_reg <= NOP_INSTR;
      rdata_reg <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (bus_ack) begin
            instr_reg <= bus_rdata;
            state     <= EXEC;
          end else if (tmo) begin
            instr_reg <= NOP_INSTR;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (!memory_en) begin
            fetch_pc <= next_pc[31:2];
            state    <= FETCH;
          end else if (al_misal) begin
            rdata_reg <= 32'h0;
            state     <= DONE;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          if (bus_ack) begin
            if (!d_we) rdata_reg <= al_rdata;
            state <= DONE;
          end else if (tmo) begin
            rdata_reg <= 32'h0;
            state     <= DONE;
          end
        end
        default: begin
          fetch_pc <= next_pc[31:2];
          state    <= FETCH;
        end
      endcase
    end
  end

  // Data-phase bus attributes, captured once in EXEC and held through DATA
  always_ff @(posedge CLK) begin
    if (state == EXEC) begin
      d_we    <= (store_size != SZ_LOAD);
      d_addr  <= mem_addr[31:2];
      d_be    <= al_be;
      d_wdata <= al_wdata;
    end
  end

  // Bus and core handshake outputs; forced idle while reset is asserted
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'h0;
    bus_be    = 4'b0000;
    bus_wdata = 32'h0;
    stall_mem = 1'b1;
    misalign  = 1'b0;
    if (reset) begin
      case (state)
        FETCH: begin
          bus_req  = 1'b1;
          bus_be   = 4'b1111;
          bus_addr = {fetch_pc, 2'b00};
        end
        EXEC: begin
          stall_mem = memory_en;
          misalign  = memory_en && al_misal;
        end
        DATA: begin
          bus_req   = 1'b1;
          bus_we    = d_we;
          bus_addr  = {d_addr, 2'b00};
          bus_be    = d_be;
          bus_wdata = d_wdata;
        end
        default: stall_mem = 1'b0;
      endcase
    end
  end

endmodule
